// File: rtl/chain1_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chain1_pkg : command field layout, opcodes and default unlock cookie |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package chain1_pkg;

    localparam int CMD_W  = 16;
    localparam int OP_W   = 4;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    localparam logic [OP_W-1:0] OP_NOP    = 4'h0;
    localparam logic [OP_W-1:0] OP_WRITE  = 4'h1;
    localparam logic [OP_W-1:0] OP_READ   = 4'h2;
    localparam logic [OP_W-1:0] OP_LOCK   = 4'h3;
    localparam logic [OP_W-1:0] OP_CLRERR = 4'h4;

    localparam logic [CMD_W-1:0] DEFAULT_COOKIE = 16'hCAFE;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdat;
    } cmd_t;

endpackage
`default_nettype wire

// File: rtl/chain1_cmd_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chain1_cmd_decoder_if : frame-load strobe plus loaded scan word      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface chain1_cmd_decoder_if;
    import chain1_pkg::*;

    logic             load;
    logic [CMD_W-1:0] data;

    modport master (output load, output data);
    modport slave  (input  load, input  data);
endinterface
`default_nettype wire

// File: rtl/chain1_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chain1_sync_edge : N-flop synchronizer with rising-edge pulse output |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module chain1_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic i_clk,
    input  wire logic i_rst_n,
    input  wire logic i_async,
    output logic      o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    // Chain and history reset high: a strobe still asserted when reset
    // releases must be seen low before it can produce a rising edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '1;
            r_hist <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule
`default_nettype wire

// File: rtl/chain1_cmd_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chain1_cmd_decoder : executes scan-loaded command words, reg file,   |
// | lock cookie, sticky error and an 8-bit PWM driven from reg[1]        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module chain1_cmd_decoder
    import chain1_pkg::*;
#(
    parameter int               SYNC_STAGES = 2,
    parameter int               NREGS       = 8,
    parameter logic [CMD_W-1:0] COOKIE      = DEFAULT_COOKIE
) (
    input  wire logic            i_clk,
    input  wire logic            i_rst_n,
    chain1_cmd_decoder_if.slave  i_frame,
    output logic [DATA_W-1:0]    o_ctrl,
    output logic                 o_pwm,
    output logic [DATA_W-1:0]    o_rdata,
    output logic                 o_valid,
    output logic                 o_locked,
    output logic                 o_err,
    output logic [7:0]           o_cmd_cnt
);

    localparam logic [ADDR_W:0] c_nregs = (ADDR_W+1)'(NREGS);

    logic              w_rise;
    cmd_t              w_cmd;
    logic              w_addr_ok;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_set_err;
    logic              w_clr_err;
    logic              w_lock;
    logic              w_unlock;
    logic [DATA_W-1:0] w_rd_val;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic              r_locked;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;
    logic              r_valid;
    logic [7:0]        r_cmd_cnt;
    logic [7:0]        r_pwm_cnt;
    logic              r_pwm;

    chain1_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_frame.load),
        .o_rise  (w_rise)
    );

    assign w_cmd     = i_frame.data;
    assign w_addr_ok = {1'b0, w_cmd.addr} < c_nregs;

    always_comb begin
        w_wr_en   = 1'b0;
        w_rd_en   = 1'b0;
        w_set_err = 1'b0;
        w_clr_err = 1'b0;
        w_lock    = 1'b0;
        w_unlock  = 1'b0;
        if (w_rise) begin
            // The cookie shares opcode space with illegal 0xC words, so it wins.
            if (i_frame.data == COOKIE) begin
                w_unlock = 1'b1;
            end else begin
                case (w_cmd.op)
                    OP_NOP:    ;
                    OP_WRITE: begin
                        if (r_locked || !w_addr_ok) w_set_err = 1'b1;
                        else                        w_wr_en   = 1'b1;
                    end
                    OP_READ: begin
                        if (!w_addr_ok) w_set_err = 1'b1;
                        else            w_rd_en   = 1'b1;
                    end
                    OP_LOCK:   w_lock    = 1'b1;
                    OP_CLRERR: w_clr_err = 1'b1;
                    default:   w_set_err = 1'b1;
                endcase
            end
        end
    end

    always_comb begin
        w_rd_val = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (w_cmd.addr == ADDR_W'(i)) w_rd_val = r_regs[i];
        end
    end

    generate
        for (genvar i = 0; i < NREGS; i++) begin : g_regs
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n)                                 r_regs[i] <= '0;
                else if (w_wr_en && w_cmd.addr == ADDR_W'(i)) r_regs[i] <= w_cmd.wdat;
            end
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_locked  <= 1'b1;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_valid   <= 1'b0;
            r_cmd_cnt <= '0;
        end else begin
            r_valid <= w_rise;
            if (w_rise)    r_cmd_cnt <= r_cmd_cnt + 8'd1;
            if (w_unlock)  r_locked  <= 1'b0;
            if (w_lock)    r_locked  <= 1'b1;
            if (w_set_err) r_err     <= 1'b1;
            if (w_clr_err) r_err     <= 1'b0;
            if (w_rd_en)   r_rdata   <= w_rd_val;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pwm_cnt <= '0;
            r_pwm     <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            r_pwm     <= r_pwm_cnt < r_regs[1];
        end
    end

    assign o_ctrl    = r_regs[0];
    assign o_pwm     = r_pwm;
    assign o_rdata   = r_rdata;
    assign o_valid   = r_valid;
    assign o_locked  = r_locked;
    assign o_err     = r_err;
    assign o_cmd_cnt = r_cmd_cnt;

endmodule
`default_nettype wire

// File: tb/tb_chain1_cmd_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_chain1_cmd_decoder : directed frames with reference-model scoreboard |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_chain1_cmd_decoder;

    typedef struct {
        logic [7:0] ctrl;
        logic [7:0] rdata;
        logic       locked;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] ctrl, rdata, cmd_cnt;
    logic       pwm, valid, locked, err;

    int checks = 0;
    int errors = 0;

    exp_t       sb_q [$];
    logic [7:0] m_regs [16];
    logic       m_locked, m_err;
    logic [7:0] m_rdata, m_cnt;

    chain1_cmd_decoder_if bus ();

    chain1_cmd_decoder dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_frame   (bus.slave),
        .o_ctrl    (ctrl),
        .o_pwm     (pwm),
        .o_rdata   (rdata),
        .o_valid   (valid),
        .o_locked  (locked),
        .o_err     (err),
        .o_cmd_cnt (cmd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_locked = 1'b1;
        m_err    = 1'b0;
        m_rdata  = 8'h00;
        m_cnt    = 8'h00;
    endtask

    task automatic model_apply(input logic [15:0] w);
        logic [3:0] a;
        a = w[11:8];
        m_cnt = m_cnt + 8'd1;
        if (w == 16'hCAFE) m_locked = 1'b0;
        else begin
            case (w[15:12])
                4'h0: ;
                4'h1: if (m_locked || a >= 4'd8) m_err = 1'b1; else m_regs[a] = w[7:0];
                4'h2: if (a >= 4'd8) m_err = 1'b1; else m_rdata = m_regs[a];
                4'h3: m_locked = 1'b1;
                4'h4: m_err = 1'b0;
                default: m_err = 1'b1;
            endcase
        end
    endtask

    task automatic send_frame(input logic [15:0] w);
        exp_t e;
        int   n;
        @(negedge clk);
        bus.data = w;
        bus.load = 1'b1;
        model_apply(w);
        sb_q.push_back('{ctrl: m_regs[0], rdata: m_rdata, locked: m_locked, err: m_err, cnt: m_cnt});
        n = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (valid) begin n = k; break; end
        end
        e = sb_q.pop_front();
        check("latency", n, 3);
        if (n != 0) begin
            check("ctrl", ctrl, e.ctrl);
            check("rdata", rdata, e.rdata);
            check("locked", locked, e.locked);
            check("err", err, e.err);
            check("cmd_cnt", cmd_cnt, e.cnt);
            @(posedge clk); #1;
            check("valid_one_cycle", valid, 1'b0);
        end
        @(negedge clk);
        bus.load = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pwm_high(output int hi);
        hi = 0;
        repeat (256) begin
            @(negedge clk);
            if (pwm) hi++;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ctrl"}, ctrl, 8'h00);
        check({tag, "_pwm"}, pwm, 1'b0);
        check({tag, "_rdata"}, rdata, 8'h00);
        check({tag, "_valid"}, valid, 1'b0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_cnt"}, cmd_cnt, 8'h00);
        check({tag, "_locked"}, locked, 1'b1);
    endtask

    initial begin
        int hi;
        int pulses;
        int k;
        rst_n    = 1'b0;
        bus.load = 1'b0;
        bus.data = 16'h0000;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_state("rst");
        pwm_high(hi);
        check("pwm_duty_0", hi, 0);

        send_frame(16'h1005);
        check("locked_write_err", err, 1'b1);
        check("locked_write_ctrl", ctrl, 8'h00);
        check("first_cnt", cmd_cnt, 8'd1);

        send_frame(16'hCAFE);
        send_frame(16'h4000);
        send_frame(16'h10A5);
        check("unlock_locked", locked, 1'b0);
        check("clrerr_err", err, 1'b0);
        check("write_ctrl", ctrl, 8'hA5);

        send_frame(16'h1140);
        send_frame(16'h2100);
        check("read_reg1", rdata, 8'h40);
        pwm_high(hi);
        check("pwm_duty_64", hi, 64);

        send_frame(16'h11FF);
        pwm_high(hi);
        check("pwm_duty_255", hi, 255);

        send_frame(16'h1805);
        check("bad_addr_err", err, 1'b1);
        send_frame(16'h4000);
        send_frame(16'h7000);
        check("bad_op_err", err, 1'b1);
        send_frame(16'h4000);
        send_frame(16'hC123);
        check("c_not_cookie_err", err, 1'b1);
        check("c_not_cookie_locked", locked, 1'b0);
        send_frame(16'h4000);
        send_frame(16'h3000);
        check("lock_locked", locked, 1'b1);
        send_frame(16'h1001);
        check("relock_write_err", err, 1'b1);
        check("relock_ctrl", ctrl, 8'hA5);
        send_frame(16'h2000);
        check("read_while_locked", rdata, 8'hA5);
        send_frame(16'h2900);
        check("bad_read_rdata", rdata, 8'hA5);

        // Narrow strobe: zero or one execution allowed.
        @(negedge clk);
        bus.data = 16'h0000;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (valid) pulses++;
        end
        check("glitch_at_most_one", pulses <= 1, 1'b1);
        m_cnt = m_cnt + 8'(pulses);
        check("glitch_cnt", cmd_cnt, m_cnt);
        repeat (4) @(negedge clk);

        k = (m_cnt == 8'd0) ? 256 : 256 - int'(m_cnt);
        for (int i = 0; i < k; i++) send_frame(16'h0000);
        check("cnt_wrap", cmd_cnt, 8'h00);

        // Reset mid-frame, released with the strobe still high.
        send_frame(16'hCAFE);
        send_frame(16'h1077);
        @(negedge clk);
        bus.data = 16'h10FF;
        bus.load = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_state("midrst");
        pulses = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (valid) pulses++;
        end
        check("no_exec_after_rst", pulses, 0);
        check("midrst_ctrl_after", ctrl, 8'h00);
        @(negedge clk);
        bus.load = 1'b0;
        repeat (4) @(negedge clk);
        send_frame(16'h2000);
        check("post_rst_locked", locked, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
